// File: rtl/wb_arbiter_2m_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    // Pick the master to grant from IDLE. With both requesting, round-robin
    // hands the bus to whoever did not own it last; fixed priority favours m0.
    function automatic logic next_winner(input logic req0, input logic req1,
                                         input logic last, input logic rr_en);
        if (req0 && req1) begin
            return rr_en ? ~last : OWNER_M0;
        end
        if (req1) begin
            return OWNER_M1;
        end
        return OWNER_M0;
    endfunction

endpackage

// File: rtl/wb_arbiter_2m_if.sv
// Pipelined Wishbone link, one instance per master port and one for the slave.
// Handshake: a transfer is accepted on a cycle where cyc & stb & !stall; the
// master holds stb/adr/we/dat_w/sel stable while stall is high. Each accepted
// transfer is answered later by exactly one ack or err, in order, while cyc
// stays high; dat_r is valid on the ack cycle.
interface wb_arbiter_2m_if #(
    parameter int AW = 12
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [31:0]   dat_w;
    logic [3:0]    sel;
    logic          stall;
    logic          ack;
    logic          err;
    logic [31:0]   dat_r;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  stall, ack, err, dat_r
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output stall, ack, err, dat_r
    );
endinterface

// File: rtl/wb_arbiter_2m_out_counter.sv
// Outstanding-transfer counter: counts accepted-but-unanswered transfers.
module wb_out_counter #(
    parameter  int MAX_OUT = 4,
    localparam int CW      = $clog2(MAX_OUT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          empty
);

    assign full  = (cnt == CW'(MAX_OUT));
    assign empty = (cnt == '0);

    // Saturating up/down count; a simultaneous accept and response cancel out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + CW'(1);
        end else if (dec && !inc && !empty) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave pipelined Wishbone arbiter. Ownership is held for a
// whole cyc assertion and only moves once every accepted transfer is answered.
module wb_arbiter_2m
    import wb_arb_pkg::*;
#(
    parameter  int AW      = 12,
    parameter  int MAX_OUT = 4,
    parameter  int RR_EN   = 1,
    localparam int CW      = $clog2(MAX_OUT + 1)
) (
    input  logic            cpu_clock_i,
    input  logic            cpu_rst_ni,
    wb_arbiter_2m_if.slave  m0,
    wb_arbiter_2m_if.slave  m1,
    wb_arbiter_2m_if.master s,
    output arb_state_t      dbg_state,
    output logic            dbg_owner,
    output logic [CW-1:0]   dbg_out_cnt
);

    arb_state_t    state, state_n;
    logic          owner, owner_n;
    logic          last_owner, last_owner_n;
    logic [CW-1:0] out_cnt;
    logic          full, empty, inc, dec, drained;
    logic          own_cyc, own_stb, other_cyc;

    assign own_cyc   = owner ? m1.cyc : m0.cyc;
    assign own_stb   = owner ? m1.stb : m0.stb;
    assign other_cyc = owner ? m0.cyc : m1.cyc;

    assign inc = s.stb & ~s.stall;
    assign dec = (s.ack | s.err) & ~empty;
    // True when nothing will be outstanding after this edge, so a master that
    // drops cyc on the cycle of its last ack hands over without a gap.
    assign drained = empty | (dec & ~inc & (out_cnt == CW'(1)));

    wb_out_counter #(.MAX_OUT(MAX_OUT)) u_out_counter (
        .clk   (cpu_clock_i),
        .rst_n (cpu_rst_ni),
        .inc   (inc),
        .dec   (dec),
        .cnt   (out_cnt),
        .full  (full),
        .empty (empty)
    );

    // State, owner and round-robin history registers.
    always_ff @(posedge cpu_clock_i) begin
        if (!cpu_rst_ni) begin
            state      <= IDLE;
            owner      <= OWNER_M0;
            last_owner <= OWNER_M1;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_owner_n;
        end
    end

    // Next-state: grant from IDLE, release or abort-drain from OWN/DRAIN.
    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_owner_n = last_owner;
        case (state)
            IDLE: begin
                if (m0.cyc || m1.cyc) begin
                    state_n = OWN;
                    owner_n = next_winner(m0.cyc, m1.cyc, last_owner, RR_EN != 0);
                end
            end
            OWN, DRAIN: begin
                if (!own_cyc || state == DRAIN) begin
                    if (drained) begin
                        last_owner_n = owner;
                        if (other_cyc) begin
                            state_n = OWN;
                            owner_n = ~owner;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        state_n = DRAIN;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Bus steering: slave side follows the owner, non-owners see a stalled bus.
    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = owner ? m1.we    : m0.we;
        s.adr    = owner ? m1.adr   : m0.adr;
        s.dat_w  = owner ? m1.dat_w : m0.dat_w;
        s.sel    = owner ? m1.sel   : m0.sel;
        m0.stall = 1'b1;
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m0.dat_r = '0;
        m1.stall = 1'b1;
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        m1.dat_r = '0;
        case (state)
            OWN: begin
                s.cyc = own_cyc;
                s.stb = own_stb & ~full;
                if (owner == OWNER_M1) begin
                    m1.stall = s.stall | full;
                    m1.ack   = s.ack & ~empty;
                    m1.err   = s.err & ~empty;
                    m1.dat_r = s.dat_r;
                end else begin
                    m0.stall = s.stall | full;
                    m0.ack   = s.ack & ~empty;
                    m0.err   = s.err & ~empty;
                    m0.dat_r = s.dat_r;
                end
            end
            DRAIN: begin
                s.cyc = 1'b1;
            end
            default: ;
        endcase
    end

    assign dbg_state   = state;
    assign dbg_owner   = owner;
    assign dbg_out_cnt = out_cnt;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_wb_arbiter_2m;
  import wb_arb_pkg::*;

  localparam int AW      = 12;
  localparam int MAX_OUT = 4;
  localparam int CW      = $clog2(MAX_OUT + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus variables ----------------
  logic          mcyc [2];
  logic          mstb [2];
  logic          mwe  [2];
  logic [AW-1:0] madr [2];
  logic [31:0]   mdat [2];
  logic [3:0]    msel [2];
  logic          s_stall, s_ack, s_err;
  logic [31:0]   s_dat;

  wb_arbiter_2m_if #(.AW(AW)) m0_if ();
  wb_arbiter_2m_if #(.AW(AW)) m1_if ();
  wb_arbiter_2m_if #(.AW(AW)) s_if ();

  assign m0_if.cyc = mcyc[0]; assign m0_if.stb = mstb[0]; assign m0_if.we = mwe[0];
  assign m0_if.adr = madr[0]; assign m0_if.dat_w = mdat[0]; assign m0_if.sel = msel[0];
  assign m1_if.cyc = mcyc[1]; assign m1_if.stb = mstb[1]; assign m1_if.we = mwe[1];
  assign m1_if.adr = madr[1]; assign m1_if.dat_w = mdat[1]; assign m1_if.sel = msel[1];
  assign s_if.stall = s_stall; assign s_if.ack = s_ack; assign s_if.err = s_err;
  assign s_if.dat_r = s_dat;

  arb_state_t    dbg_state;
  logic          dbg_owner;
  logic [CW-1:0] dbg_cnt;

  wb_arbiter_2m #(.AW(AW), .MAX_OUT(MAX_OUT), .RR_EN(1)) dut (
    .cpu_clock_i (clk),
    .cpu_rst_ni  (rst_n),
    .m0          (m0_if),
    .m1          (m1_if),
    .s           (s_if),
    .dbg_state   (dbg_state),
    .dbg_owner   (dbg_owner),
    .dbg_out_cnt (dbg_cnt)
  );

  // Fixed-priority instance: only the cyc lines matter for its grant checks.
  wb_arbiter_2m_if #(.AW(AW)) f0_if ();
  wb_arbiter_2m_if #(.AW(AW)) f1_if ();
  wb_arbiter_2m_if #(.AW(AW)) fs_if ();

  assign f0_if.cyc = mcyc[0]; assign f0_if.stb = 1'b0; assign f0_if.we = 1'b0;
  assign f0_if.adr = '0; assign f0_if.dat_w = '0; assign f0_if.sel = '0;
  assign f1_if.cyc = mcyc[1]; assign f1_if.stb = 1'b0; assign f1_if.we = 1'b0;
  assign f1_if.adr = '0; assign f1_if.dat_w = '0; assign f1_if.sel = '0;
  assign fs_if.stall = 1'b0; assign fs_if.ack = 1'b0; assign fs_if.err = 1'b0;
  assign fs_if.dat_r = '0;

  arb_state_t    fp_state;
  logic          fp_owner;
  logic [CW-1:0] fp_cnt;

  wb_arbiter_2m #(.AW(AW), .MAX_OUT(MAX_OUT), .RR_EN(0)) dut_fp (
    .cpu_clock_i (clk),
    .cpu_rst_ni  (rst_n),
    .m0          (f0_if),
    .m1          (f1_if),
    .s           (fs_if),
    .dbg_state   (fp_state),
    .dbg_owner   (fp_owner),
    .dbg_out_cnt (fp_cnt)
  );

  logic [1:0]  ostall, oack, oerr;
  logic [31:0] odat [2];
  assign ostall  = {m1_if.stall, m0_if.stall};
  assign oack    = {m1_if.ack, m0_if.ack};
  assign oerr    = {m1_if.err, m0_if.err};
  assign odat[0] = m0_if.dat_r;
  assign odat[1] = m1_if.dat_r;

  // ---------------- reference model ----------------
  // holder: -1 = bus free, 0/1 = master holding the bus.
  // draining: holder aborted and the slave still owes responses.
  // exp_q: data the slave still owes, one entry per accepted transfer.
  int          holder;
  bit          draining;
  int          last;
  logic [31:0] exp_q [$];

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] mem_fn(input logic [AW-1:0] a);
    return 32'hA5A5_0000 ^ {20'h0, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare all DUT outputs against the model for the current inputs.
  task automatic settle();
    arb_state_t st;
    int         cnt;
    bit         own;
    #1;
    cnt = exp_q.size();
    own = (holder >= 0) && !draining;
    st  = (holder < 0) ? IDLE : (draining ? DRAIN : OWN);
    chk("state", 32'(dbg_state), 32'(st));
    chk("out_cnt", 32'(dbg_cnt), cnt);
    chk("s_cyc", 32'(s_if.cyc), (holder < 0) ? 32'd0 : (draining ? 32'd1 : 32'(mcyc[holder])));
    chk("s_stb", 32'(s_if.stb), own ? 32'(mstb[holder] && cnt < MAX_OUT) : 32'd0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m%0d_stall", i), 32'(ostall[i]),
          (own && holder == i) ? 32'(s_stall || cnt == MAX_OUT) : 32'd1);
      chk($sformatf("m%0d_ack", i), 32'(oack[i]),
          (own && holder == i) ? 32'(s_ack && cnt > 0) : 32'd0);
      chk($sformatf("m%0d_err", i), 32'(oerr[i]),
          (own && holder == i) ? 32'(s_err && cnt > 0) : 32'd0);
    end
    if (own) begin
      chk("owner", 32'(dbg_owner), holder);
      chk("s_adr", 32'(s_if.adr), 32'(madr[holder]));
      chk("s_we", 32'(s_if.we), 32'(mwe[holder]));
      chk("s_dat", s_if.dat_w, mdat[holder]);
      chk("s_sel", 32'(s_if.sel), 32'(msel[holder]));
      chk("own_dat", odat[holder], s_dat);
      chk("other_dat", odat[1-holder], 32'd0);
    end
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic tick();
    bit acc, resp;
    int other;
    if (!rst_n) begin
      holder = -1; draining = 0; last = 1;
      exp_q.delete();
    end else begin
      acc  = (holder >= 0) && !draining && mstb[holder] && exp_q.size() < MAX_OUT && !s_stall;
      resp = (s_ack || s_err) && exp_q.size() > 0;
      if (acc) exp_q.push_back(mem_fn(madr[holder]));
      if (resp) void'(exp_q.pop_front());
      if (holder < 0) begin
        if (mcyc[0] && mcyc[1]) holder = 1 - last;
        else if (mcyc[0]) holder = 0;
        else if (mcyc[1]) holder = 1;
      end else if (!mcyc[holder] || draining) begin
        if (exp_q.size() == 0) begin
          last = holder;
          other = 1 - holder;
          holder = mcyc[other] ? other : -1;
          draining = 0;
        end else begin
          draining = 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int sent;
    int acks;
    for (int i = 0; i < 2; i++) begin
      mcyc[i] = 0; mstb[i] = 0; mwe[i] = 0; madr[i] = '0; mdat[i] = '0; msel[i] = '0;
    end
    s_stall = 0; s_ack = 0; s_err = 0; s_dat = '0;
    holder = -1; draining = 0; last = 1;
    repeat (2) @(negedge clk);

    // Reset state
    settle();
    chk("rst_s_cyc", 32'(s_if.cyc), 0);
    chk("rst_stall", 32'(ostall), 32'h3);
    tick();
    rst_n = 1;

    // m0 single read
    mcyc[0] = 1; mstb[0] = 1; madr[0] = 12'h010; mdat[0] = 32'h1111_0000; msel[0] = 4'hF;
    settle(); chk("t1_c1_s_cyc", 32'(s_if.cyc), 0); tick();
    settle(); chk("t1_c2_s_adr", 32'(s_if.adr), 32'h010); chk("t1_c2_s_stb", 32'(s_if.stb), 1); tick();
    mstb[0] = 0;
    settle(); tick();
    s_ack = 1; s_dat = 32'hDEADBEEF;
    settle(); chk("t1_ack", 32'(oack[0]), 1); chk("t1_dat", odat[0], 32'hDEADBEEF); tick();
    s_ack = 0;
    settle(); chk("t1_cnt0", 32'(dbg_cnt), 0); tick();
    mcyc[0] = 0;
    settle(); tick();

    // Simultaneous requests, three rounds, from reset
    rst_n = 0; settle(); tick(); rst_n = 1;
    for (int r = 0; r < 3; r++) begin
      mcyc[0] = 1; mcyc[1] = 1;
      settle(); tick();
      settle();
      chk("rr_owner", 32'(dbg_owner), r % 2);
      chk("fp_state", 32'(fp_state), 32'(OWN));
      chk("fp_owner", 32'(fp_owner), 0);
      mcyc[0] = 0; mcyc[1] = 0;
      settle(); tick();
    end

    // m1 six strobes against a slave that holds ack low
    mcyc[1] = 1; mstb[1] = 1; madr[1] = 12'h100; mdat[1] = 32'h2222_0000; msel[1] = 4'h3;
    settle(); tick();
    sent = 0; acks = 0;
    for (int k = 0; k < 4; k++) begin
      settle(); tick(); sent++; madr[1] = madr[1] + 1'b1;
    end
    settle(); chk("t3_full_stall", 32'(ostall[1]), 1); chk("t3_full_stb", 32'(s_if.stb), 0); tick();
    s_ack = 1; s_dat = 32'h0000_0001;
    settle(); if (oack[1]) acks++; tick();
    s_ack = 0;
    settle(); chk("t3_one_more_stb", 32'(s_if.stb), 1); tick(); sent++; madr[1] = madr[1] + 1'b1;
    settle(); chk("t3_full_again_stb", 32'(s_if.stb), 0); tick();
    for (int k = 0; k < 20 && acks < 6; k++) begin
      s_ack = 1; s_dat = 32'h100 + k;
      mstb[1] = (sent < 6);
      settle();
      if (s_if.stb && !s_stall) sent++;
      if (oack[1]) acks++;
      tick();
      if (mstb[1]) madr[1] = madr[1] + 1'b1;
    end
    s_ack = 0;
    chk("t3_acks_fwd", acks, 6);
    mcyc[1] = 0; mstb[1] = 0;
    settle(); tick();

    // Handoff with no idle cycle
    mcyc[0] = 1; mstb[0] = 1; madr[0] = 12'h020;
    mcyc[1] = 1; mstb[1] = 0; madr[1] = 12'h2A0;
    settle(); tick();
    settle(); tick();
    mstb[0] = 0;
    settle(); tick();
    s_ack = 1; s_dat = 32'h1234_5678; mcyc[0] = 0;
    settle(); chk("t4_last_ack", 32'(oack[0]), 1); tick();
    s_ack = 0;
    settle();
    chk("t4_state", 32'(dbg_state), 32'(OWN));
    chk("t4_owner", 32'(dbg_owner), 1);
    chk("t4_s_adr", 32'(s_if.adr), 32'h2A0);
    mcyc[1] = 0;
    settle(); tick();

    // Abort with two outstanding
    mcyc[0] = 1; mstb[0] = 1; madr[0] = 12'h030;
    settle(); tick();
    settle(); tick(); madr[0] = 12'h031;
    settle(); tick();
    mcyc[0] = 0; mstb[0] = 0;
    settle(); tick();
    settle();
    chk("t5_drain", 32'(dbg_state), 32'(DRAIN));
    chk("t5_s_cyc", 32'(s_if.cyc), 1);
    chk("t5_s_stb", 32'(s_if.stb), 0);
    s_ack = 1; s_dat = 32'hBAD0_0001;
    settle(); chk("t5_no_ack_a", 32'(oack), 0); tick();
    settle(); chk("t5_no_ack_b", 32'(oack), 0); chk("t5_still_drain", 32'(dbg_state), 32'(DRAIN)); tick();
    s_ack = 0;
    settle(); chk("t5_idle", 32'(dbg_state), 32'(IDLE));

    // Reset in the middle of a transfer with three outstanding
    mcyc[1] = 1; mstb[1] = 1; madr[1] = 12'h040;
    settle(); tick();
    for (int k = 0; k < 3; k++) begin
      settle(); tick();
    end
    mstb[1] = 0;
    settle(); chk("t6_cnt3", 32'(dbg_cnt), 3);
    rst_n = 0;
    settle(); tick();
    rst_n = 1; mcyc[1] = 0; s_ack = 1; s_dat = 32'h5555_AAAA;
    settle();
    chk("t6_s_cyc", 32'(s_if.cyc), 0);
    chk("t6_stalls", 32'(ostall), 32'h3);
    chk("t6_stray_ack", 32'(oack), 0);
    tick();
    s_ack = 0;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < 2; i++) begin
        if (mcyc[i]) begin
          if ($urandom_range(0, 7) == 0) mcyc[i] = 0;
        end else if ($urandom_range(0, 3) == 0) begin
          mcyc[i] = 1;
        end
        mstb[i] = mcyc[i] & 1'($urandom_range(0, 1));
        mwe[i]  = 1'($urandom_range(0, 1));
        madr[i] = AW'($urandom_range(0, (1 << AW) - 1));
        mdat[i] = $urandom;
        msel[i] = 4'($urandom_range(0, 15));
      end
      s_stall = ($urandom_range(0, 3) == 0);
      s_ack = 0; s_err = 0; s_dat = $urandom;
      if (exp_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        s_err = ($urandom_range(0, 7) == 0);
        s_ack = !s_err;
        s_dat = exp_q[0];
      end else if ($urandom_range(0, 19) == 0) begin
        s_ack = 1;
      end
      settle();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
